// File: rtl/tft_rect_filler.sv
// tft_rect_filler: queues solid-colour rectangle commands and streams each one
// to an SPI TFT controller as column-set, row-set and RAM-write sequences.
// Optional macro RECT_CLIP_EN: reversed bounds are swapped instead of rejected.
module tft_rect_filler #(
    parameter int COL_WIDTH  = 8,
    parameter int ROW_WIDTH  = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [COL_WIDTH-1:0] col1_in,
    input  logic [COL_WIDTH-1:0] col2_in,
    input  logic [ROW_WIDTH-1:0] row1_in,
    input  logic [ROW_WIDTH-1:0] row2_in,
    input  logic [2:0]           color_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 err_out,
    output logic                 tft_sck,
    output logic                 tft_sdi,
    output logic                 tft_dc,
    output logic                 tft_cs
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = COL_WIDTH + ROW_WIDTH + 1;
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(4 * CLK_DIV) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, CMD, PARAM, DATA, GAP} state_t;

    typedef struct packed {
        logic [COL_WIDTH-1:0] col1;
        logic [COL_WIDTH-1:0] col2;
        logic [ROW_WIDTH-1:0] row1;
        logic [ROW_WIDTH-1:0] row2;
        logic [2:0]           color;
    } cmd_t;

    state_t               state, state_next;
    cmd_t                 fifo_mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 fifo_empty, fifo_full, push, pop;
    cmd_t                 head;
    logic [COL_WIDTH-1:0] c_lo, c_hi;
    logic [ROW_WIDTH-1:0] r_lo, r_hi;
    logic                 bad;
    logic [NW-1:0]        pix_total, pix_left;
    logic [15:0]          c1_q, c2_q, r1_q, r2_q, rgb_q;
    logic [3:0]           hdr_idx;
    logic                 byte_hi;
    logic [7:0]           shreg, nxt_byte;
    logic                 nxt_dc;
    logic [2:0]           bit_cnt;
    logic [DW-1:0]        div_cnt;
    logic [GW-1:0]        gap_cnt;
    logic                 shifting, div_done, sck_fall, byte_end, last_byte, gap_done;

    function automatic logic [15:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'h0000;
            3'd1:    return 16'hFFFF;
            3'd2:    return 16'hF800;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'h001F;
            3'd5:    return 16'hFFE0;
            3'd6:    return 16'h07FF;
            default: return 16'hF81F;
        endcase
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ready_out  = !fifo_full;
    assign push       = valid_in && !fifo_full;
    assign pop        = (state == LOAD);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];
    assign busy_out   = (state != IDLE) || !fifo_empty;
    assign tft_sdi    = shreg[7];

    assign shifting  = (state == CMD) || (state == PARAM) || (state == DATA);
    assign div_done  = (div_cnt == DW'(CLK_DIV - 1));
    assign sck_fall  = shifting && tft_sck && div_done;
    assign byte_end  = sck_fall && (bit_cnt == 3'd7);
    assign last_byte = (state == DATA) && !byte_hi && (pix_left == NW'(1));
    // GAP plus the following LOAD cycle keep CS high for 4*CLK_DIV cycles
    assign gap_done  = (gap_cnt == GW'(4 * CLK_DIV - 2));

    assign pix_total = (NW'(c_hi) - NW'(c_lo) + NW'(1)) * (NW'(r_hi) - NW'(r_lo) + NW'(1));

    // Command queue: write on accepted valid, read once per LOAD
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[AW-1:0]] <= {col1_in, col2_in, row1_in, row2_in, color_in};
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Normalise the queue head into low/high bounds and flag unusable commands
    always_comb begin
`ifdef RECT_CLIP_EN
        c_lo = (head.col1 > head.col2) ? head.col2 : head.col1;
        c_hi = (head.col1 > head.col2) ? head.col1 : head.col2;
        r_lo = (head.row1 > head.row2) ? head.row2 : head.row1;
        r_hi = (head.row1 > head.row2) ? head.row1 : head.row2;
        bad  = 1'b0;
`else
        c_lo = head.col1;
        c_hi = head.col2;
        r_lo = head.row1;
        r_hi = head.row2;
        bad  = (head.col1 > head.col2) || (head.row1 > head.row2);
`endif
    end

    // Select the byte that follows the one currently shifting out
    always_comb begin
        nxt_byte = '0;
        nxt_dc   = 1'b1;
        if (state == DATA) begin
            nxt_byte = byte_hi ? rgb_q[7:0] : rgb_q[15:8];
        end else begin
            case (hdr_idx)
                4'd0: nxt_byte = c1_q[15:8];
                4'd1: nxt_byte = c1_q[7:0];
                4'd2: nxt_byte = c2_q[15:8];
                4'd3: nxt_byte = c2_q[7:0];
                4'd4: begin nxt_byte = 8'h2B; nxt_dc = 1'b0; end
                4'd5: nxt_byte = r1_q[15:8];
                4'd6: nxt_byte = r1_q[7:0];
                4'd7: nxt_byte = r2_q[15:8];
                4'd8: nxt_byte = r2_q[7:0];
                4'd9: begin nxt_byte = 8'h2C; nxt_dc = 1'b0; end
                default: nxt_byte = rgb_q[15:8];
            endcase
        end
    end

    // Engine state register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    // Engine next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = LOAD;
            LOAD:    state_next = bad ? IDLE : CMD;
            CMD:     if (byte_end) state_next = (hdr_idx == 4'd10) ? DATA : PARAM;
            PARAM:   if (byte_end && (hdr_idx == 4'd4 || hdr_idx == 4'd9)) state_next = CMD;
            DATA:    if (byte_end && last_byte) state_next = GAP;
            GAP:     if (gap_done) state_next = fifo_empty ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    // SPI serialiser: SCK divider, MSB-first shifting, byte sequencing, pulses
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tft_cs   <= 1'b1;
            tft_sck  <= 1'b0;
            tft_dc   <= 1'b0;
            done_out <= 1'b0;
            err_out  <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            hdr_idx  <= '0;
            byte_hi  <= 1'b0;
            pix_left <= '0;
            c1_q     <= '0;
            c2_q     <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
            rgb_q    <= '0;
        end else begin
            done_out <= 1'b0;
            err_out  <= 1'b0;
            case (state)
                LOAD: begin
                    c1_q     <= 16'(c_lo);
                    c2_q     <= 16'(c_hi);
                    r1_q     <= 16'(r_lo);
                    r2_q     <= 16'(r_hi);
                    rgb_q    <= palette(head.color);
                    pix_left <= pix_total;
                    if (bad) begin
                        err_out <= 1'b1;
                    end else begin
                        tft_cs  <= 1'b0;
                        tft_dc  <= 1'b0;
                        tft_sck <= 1'b0;
                        shreg   <= 8'h2A;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        hdr_idx <= '0;
                        byte_hi <= 1'b1;
                    end
                end
                CMD, PARAM, DATA: begin
                    div_cnt <= div_done ? '0 : div_cnt + DW'(1);
                    if (div_done && !tft_sck) tft_sck <= 1'b1;
                    if (sck_fall) begin
                        tft_sck <= 1'b0;
                        if (bit_cnt != 3'd7) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                        end else if (last_byte) begin
                            bit_cnt  <= '0;
                            shreg    <= '0;
                            tft_cs   <= 1'b1;
                            tft_dc   <= 1'b0;
                            done_out <= 1'b1;
                            gap_cnt  <= '0;
                        end else begin
                            bit_cnt <= '0;
                            shreg   <= nxt_byte;
                            tft_dc  <= nxt_dc;
                            if (state == DATA) begin
                                byte_hi <= !byte_hi;
                                if (!byte_hi) pix_left <= pix_left - NW'(1);
                            end else begin
                                hdr_idx <= hdr_idx + 4'd1;
                            end
                        end
                    end
                end
                GAP: gap_cnt <= gap_cnt + GW'(1);
                default: ;
            endcase
        end
    end
endmodule
